// File: rtl/uart_cmd_parser.sv
// Sequences UART receive bytes into 5-byte SYNC/CMD/ADDR/DATA/CSUM frames and
// issues single-cycle register write/read strobes, with checksum, command and timeout errors.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       busy,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
    GET_CSUM
  } state_t;

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CLKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [19:0] tmo_q, tmo_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        busy_q, busy_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  err_count_q, err_count_d;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    if (state_q == IDLE) begin
      tmo_d = '0;
      if (rx_ready && rx_data == SYNC_BYTE) begin
        state_d = GET_CMD;
      end
    end else if (rx_ready) begin
      // An arriving byte always beats a timeout that would fire this cycle.
      tmo_d = '0;
      case (state_q)
        GET_CMD: begin
          cmd_d   = rx_data;
          state_d = GET_ADDR;
        end
        GET_ADDR: begin
          addr_d  = rx_data;
          state_d = GET_DATA;
        end
        GET_DATA: begin
          data_d  = rx_data;
          state_d = GET_CSUM;
        end
        GET_CSUM: begin
          state_d = IDLE;
          if (rx_data != (cmd_q ^ addr_q ^ data_q)) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
          end else if (cmd_q == 8'h01) begin
            reg_wr_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = data_q;
          end else if (cmd_q == 8'h02) begin
            reg_rd_d    = 1'b1;
            reg_addr_d  = addr_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_q == TMO_LAST) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      tmo_d       = '0;
    end else begin
      tmo_d = tmo_q + 20'd1;
    end

    err_count_d = (frame_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised and directed bench for uart_cmd_parser; expectations come from a
// frame-level model that collects bytes into a queue and judges each complete frame.
module tb_uart_cmd_parser;

  localparam int T = 20;
  localparam logic [7:0] SYNC = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       reg_wr, reg_rd, busy, frame_err;
  logic [7:0] reg_addr, reg_wdata, err_count;
  logic [1:0] err_code;

  uart_cmd_parser #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .busy(busy), .frame_err(frame_err), .err_code(err_code), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Frame-level reference model state
  logic [7:0] q[$];
  int         idle_run;
  logic       e_wr, e_rd, e_err;
  logic [7:0] exp_addr, exp_wdata, exp_cnt;
  logic [1:0] exp_code;
  int         exp_wr_n, exp_rd_n, exp_err_n;
  int         wr_seen, rd_seen, err_seen, strobe_diff, held_diff;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    idle_run = 0;
    exp_addr = 8'h00; exp_wdata = 8'h00; exp_cnt = 8'h00; exp_code = 2'd0;
  endtask

  task automatic clear_stats();
    exp_wr_n = 0; exp_rd_n = 0; exp_err_n = 0;
    wr_seen = 0; rd_seen = 0; err_seen = 0; strobe_diff = 0; held_diff = 0;
  endtask

  task automatic model_error(input logic [1:0] code);
    e_err = 1'b1;
    exp_code = code;
    exp_err_n++;
    if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic record();
    if (reg_wr === 1'b1) wr_seen++;
    if (reg_rd === 1'b1) rd_seen++;
    if (frame_err === 1'b1) err_seen++;
    if (reg_wr !== e_wr || reg_rd !== e_rd || frame_err !== e_err || busy !== (q.size() != 0))
      strobe_diff++;
    if (reg_addr !== exp_addr || reg_wdata !== exp_wdata || err_code !== exp_code || err_count !== exp_cnt)
      held_diff++;
  endtask

  task automatic apply_byte(input logic [7:0] b);
    logic [7:0] chk;
    e_wr = 1'b0; e_rd = 1'b0; e_err = 1'b0;
    idle_run = 0;
    if (q.size() == 0) begin
      if (b == SYNC) q.push_back(b);
    end else begin
      q.push_back(b);
      if (q.size() == 5) begin
        chk = q[1] ^ q[2] ^ q[3];
        if (q[4] != chk) model_error(2'd1);
        else if (q[1] == 8'h01) begin
          e_wr = 1'b1; exp_addr = q[2]; exp_wdata = q[3]; exp_wr_n++;
        end else if (q[1] == 8'h02) begin
          e_rd = 1'b1; exp_addr = q[2]; exp_rd_n++;
        end else model_error(2'd2);
        q.delete();
      end
    end
    rx_data = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_data = 8'($urandom);
    record();
  endtask

  task automatic apply_idle(input int n);
    for (int i = 0; i < n; i++) begin
      e_wr = 1'b0; e_rd = 1'b0; e_err = 1'b0;
      idle_run++;
      if (q.size() != 0 && idle_run == T) begin
        model_error(2'd3);
        q.delete();
      end
      tick();
      record();
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] k, input int gap);
    apply_byte(SYNC); apply_idle(gap);
    apply_byte(c);    apply_idle(gap);
    apply_byte(a);    apply_idle(gap);
    apply_byte(d);    apply_idle(gap);
    apply_byte(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_ready = 1'b0;
    model_reset();
    clear_stats();
    tick();
    n_cmp++;
    if ({reg_wr, reg_rd, reg_addr, reg_wdata, busy, frame_err, err_code, err_count} !== 30'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b required all zero",
               {reg_wr, reg_rd, reg_addr, reg_wdata, busy, frame_err, err_code, err_count});
    end
    rst = 1'b0;
    apply_idle(3);
  endtask

  task automatic test_write();
    clear_stats();
    apply_byte(8'hAA); apply_byte(8'h01); apply_byte(8'h10); apply_byte(8'h5A); apply_byte(8'h4B);
    n_cmp++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h10 || reg_wdata !== 8'h5A) begin
      n_fail++;
      $display("[TB] FAIL write_latency: got wr=%b addr=%h wdata=%h required wr=1 addr=10 wdata=5a",
               reg_wr, reg_addr, reg_wdata);
    end
    apply_idle(4);
    n_cmp++;
    if (wr_seen !== 1 || err_seen !== 0 || strobe_diff !== 0) begin
      n_fail++;
      $display("[TB] FAIL write_pulses: got wr=%0d err=%0d diff=%0d required 1/0/0", wr_seen, err_seen, strobe_diff);
    end
  endtask

  task automatic test_read_resync();
    clear_stats();
    apply_byte(8'h00); apply_byte(8'hFF);
    send_frame(8'h02, 8'h33, 8'h00, 8'h31, 0);
    n_cmp++;
    if (reg_rd !== 1'b1 || reg_addr !== 8'h33 || reg_wdata !== 8'h5A) begin
      n_fail++;
      $display("[TB] FAIL read_pulse: got rd=%b addr=%h wdata=%h required rd=1 addr=33 wdata=5a",
               reg_rd, reg_addr, reg_wdata);
    end
    apply_idle(2);
    n_cmp++;
    if (rd_seen !== 1 || wr_seen !== 0 || err_count !== 8'd0 || strobe_diff !== 0) begin
      n_fail++;
      $display("[TB] FAIL read_resync: got rd=%0d wr=%0d cnt=%0d diff=%0d required 1/0/0/0",
               rd_seen, wr_seen, err_count, strobe_diff);
    end
  endtask

  task automatic test_bad_checksum();
    clear_stats();
    send_frame(8'h01, 8'h10, 8'h5A, 8'h00, 0);
    n_cmp++;
    if (frame_err !== 1'b1 || err_code !== 2'd1 || err_count !== 8'd1 || reg_wr !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bad_csum: got err=%b code=%0d cnt=%0d wr=%b required 1/1/1/0",
               frame_err, err_code, err_count, reg_wr);
    end
    send_frame(8'h01, 8'h22, 8'h77, 8'h01 ^ 8'h22 ^ 8'h77, 0);
    n_cmp++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h22 || reg_wdata !== 8'h77 || err_code !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL write_after_bad: got wr=%b addr=%h wdata=%h code=%0d required 1/22/77/1",
               reg_wr, reg_addr, reg_wdata, err_code);
    end
    apply_idle(2);
  endtask

  task automatic test_unknown_cmd();
    clear_stats();
    send_frame(8'h07, 8'h01, 8'h02, 8'h04, 1);
    n_cmp++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || err_count !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL unknown_cmd: got err=%b code=%0d cnt=%0d required 1/2/2", frame_err, err_code, err_count);
    end
    apply_idle(2);
    n_cmp++;
    if (wr_seen !== 0 || rd_seen !== 0 || reg_addr !== 8'h22 || held_diff !== 0) begin
      n_fail++;
      $display("[TB] FAIL unknown_cmd_side: got wr=%0d rd=%0d addr=%h held=%0d required 0/0/22/0",
               wr_seen, rd_seen, reg_addr, held_diff);
    end
  endtask

  task automatic test_timeout();
    clear_stats();
    apply_byte(SYNC); apply_byte(8'h01);
    apply_idle(T - 1);
    n_cmp++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout_early: got err=%b busy=%b required 0/1", frame_err, busy);
    end
    apply_idle(1);
    n_cmp++;
    if (frame_err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_fire: got err=%b code=%0d busy=%b required 1/3/0", frame_err, err_code, busy);
    end
    apply_idle(3);
    apply_byte(SYNC); apply_byte(8'h01);
    apply_idle(T - 1);
    apply_byte(8'h10);
    n_cmp++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout_race: got err=%b busy=%b required 0/1", frame_err, busy);
    end
    apply_byte(8'h5A); apply_byte(8'h4B);
    n_cmp++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h10 || reg_wdata !== 8'h5A) begin
      n_fail++;
      $display("[TB] FAIL race_write: got wr=%b addr=%h wdata=%h required 1/10/5a", reg_wr, reg_addr, reg_wdata);
    end
    apply_idle(2);
    n_cmp++;
    if (err_seen !== 1 || strobe_diff !== 0 || held_diff !== 0) begin
      n_fail++;
      $display("[TB] FAIL timeout_model: got errs=%0d diff=%0d held=%0d required 1/0/0", err_seen, strobe_diff, held_diff);
    end
  endtask

  task automatic test_random();
    logic [7:0] c, a, d, k;
    int gap, sel;
    clear_stats();
    for (int f = 0; f < 150; f++) begin
      for (int g = 0; g < $urandom_range(0, 2); g++) apply_byte(8'($urandom));
      sel = $urandom_range(0, 9);
      c = (sel < 4) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      k = c ^ a ^ d;
      if ($urandom_range(0, 7) == 0) k = k ^ 8'($urandom_range(1, 255));
      sel = $urandom_range(0, 19);
      gap = (sel == 0) ? T + $urandom_range(0, 3) : (sel == 1) ? T - 1 : $urandom_range(0, 2);
      send_frame(c, a, d, k, gap);
      apply_idle($urandom_range(0, 2));
    end
    apply_idle(T + 2);
    n_cmp++;
    if (strobe_diff !== 0 || held_diff !== 0) begin
      n_fail++;
      $display("[TB] FAIL random_cycles: got strobe_diff=%0d held_diff=%0d required 0/0", strobe_diff, held_diff);
    end
    n_cmp++;
    if (wr_seen !== exp_wr_n || rd_seen !== exp_rd_n || err_seen !== exp_err_n) begin
      n_fail++;
      $display("[TB] FAIL random_counts: got wr=%0d rd=%0d err=%0d required %0d/%0d/%0d",
               wr_seen, rd_seen, err_seen, exp_wr_n, exp_rd_n, exp_err_n);
    end
  endtask

  task automatic test_saturation_reset();
    clear_stats();
    for (int f = 0; f < 300; f++) send_frame(8'h01, 8'h10, 8'h5A, 8'h00, 0);
    apply_idle(1);
    n_cmp++;
    if (err_count !== 8'd255 || strobe_diff !== 0) begin
      n_fail++;
      $display("[TB] FAIL saturation: got cnt=%0d diff=%0d required 255/0", err_count, strobe_diff);
    end
    apply_byte(SYNC); apply_byte(8'h01); apply_byte(8'h44);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({reg_wr, reg_rd, reg_addr, reg_wdata, busy, frame_err, err_code, err_count} !== 30'd0) begin
      n_fail++;
      $display("[TB] FAIL midframe_reset: got %b required all zero",
               {reg_wr, reg_rd, reg_addr, reg_wdata, busy, frame_err, err_code, err_count});
    end
    tick();
    rst = 1'b0;
    model_reset();
    clear_stats();
    apply_idle(2);
    send_frame(8'h01, 8'h3C, 8'hC3, 8'h01 ^ 8'h3C ^ 8'hC3, 0);
    n_cmp++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h3C || reg_wdata !== 8'hC3 || err_count !== 8'd0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_write: got wr=%b addr=%h wdata=%h cnt=%0d err=%b required 1/3c/c3/0/0",
               reg_wr, reg_addr, reg_wdata, err_count, frame_err);
    end
    apply_idle(2);
    n_cmp++;
    if (wr_seen !== 1 || strobe_diff !== 0 || held_diff !== 0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_model: got wr=%0d diff=%0d held=%0d required 1/0/0", wr_seen, strobe_diff, held_diff);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_resync();
    test_bad_checksum();
    test_unknown_cmd();
    test_timeout();
    test_random();
    test_saturation_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
